traffic_sensor_conditioner: RTL and testbench

//  Front end for the traffic light controller. Synchronises and debounces the two raw
//  car-sensor push-buttons (street A, street B) and latches each press as a pending

---
 rtl/traffic_sensor_conditioner.sv | 171 +++++++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// Sensor front end for the traffic light FSM: sync + debounce of two car sensors,
// optional request latching (SENSOR_LATCH_EN) and the periodic step-enable tick.
module traffic_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 300_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_a,
  input  logic btn_b,
  input  logic a_green,
  input  logic b_green,
  output logic SA,
  output logic SB,
  output logic tick
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TW = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND_PRESS,
    ST_PRESSED,
    ST_PEND_RELEASE
  } db_state_e;

  logic [1:0] btn_raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] db;

  assign btn_raw = {btn_b, btn_a};

  // Two-flop synchronisers for the asynchronous sensor inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    db_state_e     state_q;
    db_state_e     state_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic          db_q;
    logic          db_d;
    logic          s;

    assign s     = sync2_q[c];
    assign db[c] = db_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        db_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
      end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive identical samples
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      unique case (state_q)
        ST_IDLE: begin
          if (s) begin
            state_d = ST_PEND_PRESS;
            cnt_d   = DW'(1);
          end
        end
        ST_PEND_PRESS: begin
          if (!s) begin
            state_d = ST_IDLE;
          end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            state_d = ST_PRESSED;
            db_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        ST_PRESSED: begin
          if (!s) begin
            state_d = ST_PEND_RELEASE;
            cnt_d   = DW'(1);
          end
        end
        ST_PEND_RELEASE: begin
          if (s) begin
            state_d = ST_PRESSED;
          end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            state_d = ST_IDLE;
            db_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;
  logic          tick_q;
  logic          tick_d;

  // Free-running tick divider; tick_q rises on edge TICK_CYCLES after reset
  always_comb begin
    tick_d     = (tick_cnt_q == TW'(TICK_CYCLES - 1));
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  assign tick = tick_q;

`ifdef SENSOR_LATCH_EN
  logic [1:0] green;
  logic [1:0] db_dly_q;
  logic [1:0] req_q;
  logic [1:0] req_d;

  assign green = {b_green, a_green};

  // Set on the cycle after a debounced press; set has priority over the green-tick clear
  always_comb begin
    req_d = (db & ~db_dly_q) | (req_q & ~({2{tick_q}} & green));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_dly_q <= '0;
      req_q    <= '0;
    end else begin
      db_dly_q <= db;
      req_q    <= req_d;
    end
  end

  assign SA = req_q[0];
  assign SB = req_q[1];
`else
  logic unused_green;
  assign unused_green = a_green ^ b_green;

  assign SA = db[0];
  assign SB = db[1];
`endif

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Randomised scoreboard bench for traffic_sensor_conditioner (DEBOUNCE_CYCLES=4, TICK_CYCLES=8).
module tb_traffic_sensor_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_a = 1'b0;
  logic btn_b = 1'b0;
  logic a_green = 1'b0;
  logic b_green = 1'b0;
  logic SA, SB, tick;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];

  // Reference model state
  int       m_n;
  bit       m_tick;
  bit       m_db[2];
  bit       m_dbp[2];
  bit       m_req[2];
  bit [1:0] m_dly[2];
  bit       m_last[2];
  int       m_run[2];

  always #5 clk = ~clk;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .TICK_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_a(btn_a),
    .btn_b(btn_b),
    .a_green(a_green),
    .b_green(b_green),
    .SA(SA),
    .SB(SB),
    .tick(tick)
  );

  task automatic model_reset();
    m_n = 0;
    m_tick = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_db[c] = 1'b0;
      m_dbp[c] = 1'b0;
      m_req[c] = 1'b0;
      m_dly[c] = 2'b00;
      m_last[c] = 1'b0;
      m_run[c] = 0;
    end
  endtask

  task automatic model_step();
    bit old_tick;
    bit b, g, s, set, clr;
    old_tick = m_tick;
    m_n++;
    m_tick = (m_n % T) == 0;
    for (int c = 0; c < 2; c++) begin
      b = (c == 0) ? btn_a : btn_b;
      g = (c == 0) ? a_green : b_green;
      s = m_dly[c][1];
      m_dly[c] = {m_dly[c][0], b};
      set = m_db[c] && !m_dbp[c];
      clr = old_tick && g;
      m_dbp[c] = m_db[c];
      if (m_run[c] > 0 && s == m_last[c]) m_run[c]++;
      else begin
        m_last[c] = s;
        m_run[c] = 1;
      end
      if (m_run[c] >= D && m_last[c] != m_db[c]) m_db[c] = m_last[c];
      m_req[c] = set || (m_req[c] && !clr);
    end
  endtask

  // Model advances on every edge and queues the expected outputs for that cycle
  initial begin
    logic [2:0] e;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
`ifdef SENSOR_LATCH_EN
      e = {m_req[0], m_req[1], m_tick};
`else
      e = {m_db[0], m_db[1], m_tick};
`endif
      exp_q.push_back(e);
    end
  end

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, got, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest expected entry, away from the edge
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("SA", SA, e[2]);
        check("SB", SB, e[1]);
        check("tick", tick, e[0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    int hold_a, hold_b;
    rst_n = 1'b0;
    btn_a = 1'b1;
    btn_b = 1'b1;
    #1;
    check("reset_SA", SA, 1'b0);
    check("reset_SB", SB, 1'b0);
    check("reset_tick", tick, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(30);
    btn_a = 1'b0;
    btn_b = 1'b0;
    step(12);

    // Bouncing street A, then steady press
    for (int i = 0; i < 10; i++) begin
      btn_a = ~btn_a;
      step(2);
    end
    btn_a = 1'b1;
    step(15);
    btn_a = 1'b0;
    a_green = 1'b1;
    step(20);
    a_green = 1'b0;

    // Street B request held until served on green
    btn_b = 1'b1;
    step(8);
    btn_b = 1'b0;
    step(40);
    b_green = 1'b1;
    step(20);

    // New press whose set coincides with a green tick clear
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    btn_b = 1'b1;
    step(12);
    btn_b = 1'b0;
    step(12);
    b_green = 1'b0;

    // Reset while a press is pending
    btn_a = 1'b1;
    step(3);
    rst_n = 1'b0;
    step(2);
    btn_a = 1'b0;
    rst_n = 1'b1;
    step(20);

    hold_a = 0;
    hold_b = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold_a == 0) begin
        btn_a = 1'($urandom_range(0, 1));
        hold_a = $urandom_range(1, 9);
      end
      if (hold_b == 0) begin
        btn_b = 1'($urandom_range(0, 1));
        hold_b = $urandom_range(1, 9);
      end
      hold_a--;
      hold_b--;
      if ($urandom_range(0, 15) == 0) a_green = ~a_green;
      if ($urandom_range(0, 15) == 0) b_green = ~b_green;
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    rst_n = 1'b1;
    step(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
